// File: rtl/adc_spi_responder.sv
// SPI responder for the two-frame ADC link: the address frame selects a channel,
// and the data frame returns a 12-bit sample on MISO. All SPI pins are oversampled on clk.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] sample_in,
  output logic [2:0]  ch_addr,
  output logic        addr_valid,
  output logic        data_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int TX_W  = LEAD_ZEROS + 12;
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, ADDR, GAP, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0] bit_cnt;
  logic [13:0]      rx_sh;
  logic [TX_W-1:0]  tx_sh;

  logic av_nxt, dd_nxt, fe_nxt, tx_load;

  // Synchronisers reset to the idle bus levels so that leaving reset cannot create an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign ss_rise   =  ss_s   & ~ss_d;
  assign ss_fall   = ~ss_s   &  ss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frames are judged only when SS_n rises, by the number of SCLK rises counted.
  always_comb begin
    state_nxt = state;
    av_nxt    = 1'b0;
    dd_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    tx_load   = 1'b0;
    unique case (state)
      IDLE: if (ss_fall) state_nxt = ADDR;
      ADDR: if (ss_rise) begin
        if (bit_cnt == CNT_FULL) begin
          state_nxt = GAP;
          av_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
          fe_nxt    = 1'b1;
        end
      end
      GAP: if (ss_fall) begin
        state_nxt = DATA;
        tx_load   = 1'b1;
      end
      DATA: if (ss_rise) begin
        state_nxt = IDLE;
        if (bit_cnt == CNT_FULL) dd_nxt = 1'b1;
        else                     fe_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rise that coincides with the SS_n fall is swallowed by the clear; SS_n high gates all edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
    end else if (sclk_rise && !ss_s && bit_cnt != CNT_SAT) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Only the low 14 word bits are kept; the two top bits fall off the end unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= '0;
    end else if (sclk_fall && !ss_s && state == ADDR) begin
      rx_sh <= {rx_sh[12:0], mosi_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh <= '0;
    end else if (tx_load) begin
      tx_sh <= TX_W'(sample_in);
    end else if (sclk_rise && !ss_s && state == DATA) begin
      tx_sh <= {tx_sh[TX_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_addr    <= '0;
      addr_valid <= 1'b0;
      data_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      addr_valid <= av_nxt;
      data_done  <= dd_nxt;
      frame_err  <= fe_nxt;
      if (av_nxt) ch_addr <= rx_sh[13:11];
    end
  end

  assign MISO = (state == DATA && !ss_s) ? tx_sh[TX_W-1] : 1'b0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a bit-banged SPI master drives both frames,
// while queued expectations for the channel and the sample are checked as results appear.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b1;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] sample_in = '0;
  logic [2:0]  ch_addr;
  logic        addr_valid, data_done, frame_err, busy;

  int n_compared = 0;
  int n_mismatched = 0;
  int av_pulses = 0;
  int dd_pulses = 0;
  int fe_pulses = 0;
  logic [2:0]  last_ch = '0;
  logic [2:0]  exp_ch_q[$];
  logic [11:0] exp_sample_q[$];
  logic [2:0]  ch_seen[$];

  adc_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .sample_in(sample_in), .ch_addr(ch_addr), .addr_valid(addr_valid),
    .data_done(data_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Each channel update is matched against the next queued address frame.
  always @(negedge clk) begin
    if (rst_n && addr_valid) begin
      av_pulses++;
      check_output("addr_valid with address pending", 16'(exp_ch_q.size() != 0), 16'd1);
      if (exp_ch_q.size() != 0) check_output("ch_addr", 16'(ch_addr), 16'(exp_ch_q.pop_front()));
      ch_seen.push_back(ch_addr);
    end
    if (rst_n && data_done) dd_pulses++;
    if (rst_n && frame_err) fe_pulses++;
  end

  // Master: MOSI changes after each rise, SCLK falls, then rises, and MISO is read late in the high phase.
  task automatic spi_frame(input logic [15:0] word, input int rises, input int tail,
                           input int change_rise, input logic [11:0] late_sample,
                           output logic [15:0] rx);
    rx = '0;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < rises; i++) begin
      MOSI = (i < 16) ? word[15-i] : 1'b0;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      if (i + 1 == change_rise) sample_in = late_sample;
      repeat (8) @(negedge clk);
      rx = {rx[14:0], MISO};
    end
    SS_n = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [2:0] ch, input logic [11:0] sample, input int gap_clks,
                                input int change_rise, input logic [11:0] late_sample);
    logic [15:0] rx;
    int av0, dd0, fe0;
    av0 = av_pulses; dd0 = dd_pulses; fe0 = fe_pulses;
    exp_ch_q.push_back(ch);
    last_ch = ch;
    spi_frame({2'b00, ch, 11'b0}, 16, gap_clks, -1, 12'h000, rx);
    if (gap_clks > 4) check_output("busy in gap", 16'(busy), 16'd1);
    sample_in = sample;
    exp_sample_q.push_back(sample);
    spi_frame(16'h0000, 16, 8, change_rise, late_sample, rx);
    check_output("sample result", rx, {4'h0, exp_sample_q.pop_front()});
    check_output("addr_valid pulses", 16'(av_pulses - av0), 16'd1);
    check_output("data_done pulses", 16'(dd_pulses - dd0), 16'd1);
    check_output("frame_err pulses", 16'(fe_pulses - fe0), 16'd0);
    check_output("busy after data frame", 16'(busy), 16'd0);
  endtask

  initial begin
    logic [15:0] rx;
    int dd0, fe0, av0;

    @(negedge clk);
    check_output("reset outputs", 16'({MISO, ch_addr, addr_valid, data_done, frame_err, busy}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] basic conversion ch 5");
    apply_stimulus(3'd5, 12'hA5C, 10, -1, 12'h000);
    check_output("ch_addr after ch 5", 16'(ch_addr), 16'd5);

    $display("[TB] back-to-back ch 3 then ch 7");
    ch_seen.delete();
    apply_stimulus(3'd3, 12'h001, 6, -1, 12'h000);
    apply_stimulus(3'd7, 12'hFFF, 1, -1, 12'h000);
    check_output("ch_seen count", 16'(ch_seen.size()), 16'd2);
    if (ch_seen.size() == 2) begin
      check_output("ch_seen first", 16'(ch_seen[0]), 16'd3);
      check_output("ch_seen second", 16'(ch_seen[1]), 16'd7);
    end

    $display("[TB] address frame cut after 9 rises");
    av0 = av_pulses; fe0 = fe_pulses;
    spi_frame({2'b00, 3'd1, 11'b0}, 9, 8, -1, 12'h000, rx);
    check_output("short frame_err pulses", 16'(fe_pulses - fe0), 16'd1);
    check_output("short addr_valid pulses", 16'(av_pulses - av0), 16'd0);
    check_output("ch_addr kept", 16'(ch_addr), 16'(last_ch));
    check_output("busy after short frame", 16'(busy), 16'd0);
    apply_stimulus(3'd6, 12'h5A3, 6, -1, 12'h000);

    $display("[TB] sample_in changes mid data frame");
    apply_stimulus(3'd1, 12'h123, 6, 3, 12'h456);

    $display("[TB] reset at rise 8 of data frame");
    exp_ch_q.push_back(3'd4);
    spi_frame({2'b00, 3'd4, 11'b0}, 16, 6, -1, 12'h000, rx);
    sample_in = 12'h3C3;
    dd0 = dd_pulses; fe0 = fe_pulses;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      if (i < 7) repeat (8) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check_output("busy before reset", 16'(busy), 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("outputs in reset", 16'({MISO, ch_addr, addr_valid, data_done, frame_err, busy}), 16'd0);
    SS_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_output("no data_done after reset", 16'(dd_pulses - dd0), 16'd0);
    check_output("no frame_err after reset", 16'(fe_pulses - fe0), 16'd0);
    apply_stimulus(3'd2, 12'h7E1, 6, -1, 12'h000);
    check_output("ch_addr after reset txn", 16'(ch_addr), 16'd2);

    $display("[TB] SCLK toggling with SS_n high");
    av0 = av_pulses; dd0 = dd_pulses; fe0 = fe_pulses;
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0;
      MOSI = i[0];
      repeat (6) @(negedge clk);
      check_output("MISO idle", 16'(MISO), 16'd0);
      SCLK = 1'b1;
      repeat (6) @(negedge clk);
    end
    check_output("idle busy", 16'(busy), 16'd0);
    check_output("idle pulses", 16'((av_pulses - av0) + (dd_pulses - dd0) + (fe_pulses - fe0)), 16'd0);
    check_output("leftover channel expectations", 16'(exp_ch_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
